// File: rtl/psum_accum_pkg.sv
// Shared types and lane helpers for the psum read-modify-write accumulator.
package psum_accum_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   // Upper bound on any flattened lane vector handed to lane_sext.
   localparam int VEC_MAX = 1024;

   // Extract lane k of width w from a flattened vector, sign-extended to 64 bits.
   function automatic logic signed [63:0] lane_sext(input logic [VEC_MAX-1:0] vec,
                                                    input int k, input int w);
      logic signed [63:0] r;
      r = signed'(64'(vec >> (k*w)));
      r = (r <<< (64-w)) >>> (64-w);
      return r;
   endfunction

   // Clamp a signed value into the w-bit two's complement range.
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w-1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/psum_accum_rmw_if.sv
// psum beat stream and psum buffer memory bus for psum_accum_rmw.
interface psum_accum_rmw_if #(
   parameter int BIT_WIDTH  = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int NUM_KERNEL = 4,
   parameter int ADDR_WIDTH = 16
);
   logic [NUM_KERNEL*BIT_WIDTH-1:0] psum_dat;
   logic                            psum_vld;
   logic                            psum_rdy;
   logic [ADDR_WIDTH-1:0]           mem_radd;
   logic                            mem_rden;
   logic [NUM_KERNEL*ACC_WIDTH-1:0] mem_odat;
   logic                            mem_oval;
   logic [ADDR_WIDTH-1:0]           mem_wadd;
   logic                            mem_wren;
   logic [NUM_KERNEL*ACC_WIDTH-1:0] mem_idat;

   modport slave (
      input  psum_dat, psum_vld, mem_odat, mem_oval,
      output psum_rdy, mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat
   );

   modport master (
      output psum_dat, psum_vld, mem_odat, mem_oval,
      input  psum_rdy, mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat
   );
endinterface

// File: rtl/psum_accum_rmw_fifo.sv
// In-flight FIFO: holds each accepted beat and its address while its buffer read is outstanding.
module psum_inflight_fifo #(
   parameter  int WIDTH = 48,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      cnt
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   assign rdata = mem[rp];
endmodule

// File: rtl/psum_accum_rmw.sv
// Multi-pass psum accumulator: pass 0 writes beats, later passes read-add-write the psum buffer.
// Build option PSUM_SAT_EN: saturating lane adds; otherwise lane adds wrap.
module psum_accum_rmw
   import psum_accum_pkg::*;
#(
   parameter int BIT_WIDTH  = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int NUM_KERNEL = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_len,
   input  logic [7:0]            cfg_npass,
   psum_accum_rmw_if.slave       bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int PW = NUM_KERNEL*BIT_WIDTH;
   localparam int FW = PW + ADDR_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e                               state;
   logic [ADDR_WIDTH-1:0]                len_r, addr, pop_addr;
   logic [7:0]                           npass_r, pass;
   logic [CW-1:0]                        fifo_cnt;
   logic [FW-1:0]                        fifo_rd;
   logic [PW-1:0]                        pop_psum;
   logic                                 acc, rmw, push, pop, spurious, last_addr;
   logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0] sext_lane, sum_lane;

   // Beats are held off at a full FIFO so every outstanding read has a slot for its psum.
   assign bus.psum_rdy = (state == RUN) && (fifo_cnt < CW'(FIFO_DEPTH));
   assign acc          = bus.psum_vld && bus.psum_rdy;
   assign rmw          = (pass != '0);
   assign push         = acc && rmw;
   assign pop          = bus.mem_oval && (fifo_cnt != '0);
   assign spurious     = bus.mem_oval && (fifo_cnt == '0);
   assign bus.mem_rden = push;
   assign bus.mem_radd = addr;
   assign last_addr    = (addr == len_r - 1'b1);
   assign {pop_addr, pop_psum} = fifo_rd;

   psum_inflight_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({addr, bus.psum_dat}),
      .rdata (fifo_rd),
      .cnt   (fifo_cnt)
   );

   for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
      logic signed [63:0] ps_in, ps_pop, od, sum;
      assign ps_in  = lane_sext(VEC_MAX'(bus.psum_dat), k, BIT_WIDTH);
      assign ps_pop = lane_sext(VEC_MAX'(pop_psum), k, BIT_WIDTH);
      assign od     = lane_sext(VEC_MAX'(bus.mem_odat), k, ACC_WIDTH);
`ifdef PSUM_SAT_EN
      assign sum    = sat_clamp(od + ps_pop, ACC_WIDTH);
`else
      assign sum    = od + ps_pop;
`endif
      assign sext_lane[k] = ACC_WIDTH'(ps_in);
      assign sum_lane[k]  = ACC_WIDTH'(sum);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         len_r        <= '0;
         npass_r      <= '0;
         addr         <= '0;
         pass         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         bus.mem_wren <= 1'b0;
         bus.mem_wadd <= '0;
         bus.mem_idat <= '0;
      end else begin
         done         <= 1'b0;
         bus.mem_wren <= 1'b0;
         // FIFO is always empty in pass 0, so the two write sources never collide.
         if (pop) begin
            bus.mem_wren <= 1'b1;
            bus.mem_wadd <= pop_addr;
            bus.mem_idat <= sum_lane;
         end else if (acc && !rmw) begin
            bus.mem_wren <= 1'b1;
            bus.mem_wadd <= addr;
            bus.mem_idat <= sext_lane;
         end
         if (spurious) err <= 1'b1;

         case (state)
            IDLE: if (start) begin
               len_r   <= (cfg_len == '0) ? ADDR_WIDTH'(1) : cfg_len;
               npass_r <= (cfg_npass == '0) ? 8'd1 : cfg_npass;
               addr    <= '0;
               pass    <= '0;
               err     <= spurious;
               busy    <= 1'b1;
               state   <= RUN;
            end
            RUN: if (acc) begin
               if (last_addr) begin
                  addr  <= '0;
                  state <= DRAIN;
               end else begin
                  addr  <= addr + 1'b1;
               end
            end
            // Empty FIFO means the final write of the pass is on the bus this cycle.
            DRAIN: if (fifo_cnt == '0) begin
               if (pass == npass_r - 1'b1) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  pass  <= pass + 1'b1;
                  state <= RUN;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
